// File: rtl/enc_link_pkg.sv
// Shared types and helpers for the reduced-line encoded link receiver.
package enc_link_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 2**CODE_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } q_state_t;

    // Expand a binary line index into its one-hot line set.
    function automatic logic [OUT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/link_fifo2.sv
// Two-entry code-word queue. Besides the registered state/head it exposes the
// next-cycle state/head so the consumer can register its outputs with no
// extra cycle of latency.
module link_fifo2
    import enc_link_pkg::*;
#(
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output q_state_t          state,
    output logic [CODE_W-1:0] head,
    output q_state_t          nxt_state,
    output logic [CODE_W-1:0] nxt_head
);

    logic [CODE_W-1:0] tail;
    logic [CODE_W-1:0] nxt_tail;

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= nxt_state;
            head  <= nxt_head;
            tail  <= nxt_tail;
        end
    end

    // Occupancy transitions; a push in FULL cannot occur since in_ready is low.
    always_comb begin
        nxt_state = state;
        nxt_head  = head;
        nxt_tail  = tail;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    nxt_state = ONE;
                    nxt_head  = din;
                end
            end
            ONE: begin
                if (push && pop) begin
                    nxt_head = din;
                end else if (push) begin
                    nxt_state = FULL;
                    nxt_tail  = din;
                end else if (pop) begin
                    nxt_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    nxt_state = ONE;
                    nxt_head  = tail;
                end
            end
            default: nxt_state = EMPTY;
        endcase
    end

endmodule

// File: rtl/decoder_link_rx.sv
// Receive side of the encoded link: queues binary line indices and presents
// the registered one-hot line set, with a delivered-word counter.
// Optional macro PARITY_CHECK_EN adds in_par / sticky par_err and drops
// words failing even parity.
module decoder_link_rx
    import enc_link_pkg::*;
#(
    parameter int CODE_W = enc_link_pkg::CODE_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
`ifdef PARITY_CHECK_EN
    input  logic                 in_par,
    output logic                 par_err,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**CODE_W-1:0] out_y,
    output logic [CODE_W-1:0]    out_code,
    output logic [CNT_W-1:0]     dec_cnt
);

    localparam int OUT_W = 2**CODE_W;

    q_state_t          state;
    q_state_t          nxt_state;
    logic [CODE_W-1:0] head;
    logic [CODE_W-1:0] nxt_head;
    logic [OUT_W-1:0]  nxt_y;
    logic              in_fire;
    logic              word_ok;
    logic              push;
    logic              pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = in_fire && word_ok;

`ifdef PARITY_CHECK_EN
    assign word_ok = (in_par == ^in_code);
`else
    assign word_ok = 1'b1;
`endif

    link_fifo2 #(
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (in_code),
        .state     (state),
        .head      (head),
        .nxt_state (nxt_state),
        .nxt_head  (nxt_head)
    );

    generate
        if (CODE_W == enc_link_pkg::CODE_W) begin : g_pkg_dec
            assign nxt_y = onehot_of(nxt_head);
        end else begin : g_gen_dec
            assign nxt_y = OUT_W'(1) << nxt_head;
        end
    endgenerate

    // Output lines are decoded from the queue's next head so a word accepted
    // at an edge is on out_* right after that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_y    <= '0;
            out_code <= '0;
        end else if (nxt_state == EMPTY) begin
            out_y    <= '0;
            out_code <= '0;
        end else begin
            out_y    <= nxt_y;
            out_code <= nxt_head;
        end
    end

    // Delivered-word counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (pop) begin
            dec_cnt <= dec_cnt + CNT_W'(1);
        end
    end

`ifdef PARITY_CHECK_EN
    // Sticky flag for any handshaken word that failed even parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (in_fire && !word_ok) begin
            par_err <= 1'b1;
        end
    end
`else
    logic unused_head;
    assign unused_head = ^head;
`endif

endmodule

// File: tb/tb_decoder_link_rx.sv
// Directed self-checking bench for decoder_link_rx (counter narrowed to 4 bits).
module tb_decoder_link_rx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [2:0] out_code;
    logic [3:0] dec_cnt;
`ifdef PARITY_CHECK_EN
    logic       in_par;
    logic       par_err;
`endif

    int checks = 0;
    int passes = 0;

    decoder_link_rx #(
        .CODE_W (3),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
`ifdef PARITY_CHECK_EN
        .in_par    (in_par),
        .par_err   (par_err),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_code  (out_code),
        .dec_cnt   (dec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] code);
        in_valid = v;
        in_code  = code;
`ifdef PARITY_CHECK_EN
        in_par   = ^code;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0);
        out_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
        checks++; if (out_y !== 8'h00) $display("FAIL reset_out_y got %h exp 00", out_y); else passes++;
        checks++; if (out_code !== 3'd0) $display("FAIL reset_out_code got %0d exp 0", out_code); else passes++;
        checks++; if (dec_cnt !== 4'd0) $display("FAIL reset_dec_cnt got %0d exp 0", dec_cnt); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passes++;
`ifdef PARITY_CHECK_EN
        checks++; if (par_err !== 1'b0) $display("FAIL reset_par_err got %b exp 0", par_err); else passes++;
`endif
    endtask

    task automatic test_walking();
        logic [7:0] exp_y [8];
        exp_y = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i));
            cycle();
            checks++; if (out_y !== exp_y[i] || out_valid !== 1'b1 || out_code !== 3'(i))
                $display("FAIL walk_%0d got y=%h v=%b c=%0d exp y=%h v=1 c=%0d", i, out_y, out_valid, out_code, exp_y[i], i);
            else passes++;
        end
        drive(1'b0, 3'd0);
        cycle();
        checks++; if (out_valid !== 1'b0 || out_y !== 8'h00) $display("FAIL walk_drain got v=%b y=%h exp v=0 y=00", out_valid, out_y); else passes++;
        checks++; if (dec_cnt !== 4'd8) $display("FAIL walk_dec_cnt got %0d exp 8", dec_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd5);
        cycle();
        checks++; if (out_y !== 8'h20 || in_ready !== 1'b1) $display("FAIL bp_first got y=%h rdy=%b exp y=20 rdy=1", out_y, in_ready); else passes++;
        drive(1'b1, 3'd2);
        cycle();
        checks++; if (out_y !== 8'h20 || in_ready !== 1'b0) $display("FAIL bp_full got y=%h rdy=%b exp y=20 rdy=0", out_y, in_ready); else passes++;
        drive(1'b1, 3'd1);
        cycle();
        checks++; if (out_y !== 8'h20 || out_code !== 3'd5 || in_ready !== 1'b0) $display("FAIL bp_hold got y=%h c=%0d rdy=%b exp y=20 c=5 rdy=0", out_y, out_code, in_ready); else passes++;
        drive(1'b0, 3'd0);
        out_ready = 1'b1;
        cycle();
        checks++; if (out_y !== 8'h04 || in_ready !== 1'b1 || dec_cnt !== 4'd9) $display("FAIL bp_second got y=%h rdy=%b cnt=%0d exp y=04 rdy=1 cnt=9", out_y, in_ready, dec_cnt); else passes++;
        cycle();
        checks++; if (out_valid !== 1'b0 || dec_cnt !== 4'd10) $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=10", out_valid, dec_cnt); else passes++;
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        drive(1'b1, 3'd3);
        cycle();
        checks++; if (out_y !== 8'h08) $display("FAIL pp_head got y=%h exp 08", out_y); else passes++;
        drive(1'b1, 3'd6);
        out_ready = 1'b1;
        cycle();
        checks++; if (out_y !== 8'h40 || out_valid !== 1'b1 || in_ready !== 1'b1 || dec_cnt !== 4'd11)
            $display("FAIL pp_swap got y=%h v=%b rdy=%b cnt=%0d exp y=40 v=1 rdy=1 cnt=11", out_y, out_valid, in_ready, dec_cnt);
        else passes++;
        drive(1'b0, 3'd0);
        cycle();
        checks++; if (out_valid !== 1'b0 || dec_cnt !== 4'd12) $display("FAIL pp_drain got v=%b cnt=%0d exp v=0 cnt=12", out_valid, dec_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 3'd4);
        cycle();
        drive(1'b1, 3'd1);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_y !== 8'h00 || in_ready !== 1'b1 || dec_cnt !== 4'd0)
            $display("FAIL midrst_async got v=%b y=%h rdy=%b cnt=%0d exp v=0 y=00 rdy=1 cnt=0", out_valid, out_y, in_ready, dec_cnt);
        else passes++;
        cycle();
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_no_take got v=%b exp 0", out_valid); else passes++;
        drive(1'b0, 3'd0);
        rst_n = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0 || out_y !== 8'h00) $display("FAIL midrst_release got v=%b y=%h exp v=0 y=00", out_valid, out_y); else passes++;
    endtask

    task automatic test_counter_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'(i));
            cycle();
        end
        drive(1'b0, 3'd0);
        cycle();
        checks++; if (dec_cnt !== 4'd1 || out_valid !== 1'b0) $display("FAIL wrap got cnt=%0d v=%b exp cnt=1 v=0", dec_cnt, out_valid); else passes++;
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        do_reset();
        in_valid = 1'b1;
        in_code  = 3'd7;
        in_par   = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0 || par_err !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL par_bad got v=%b err=%b rdy=%b exp v=0 err=1 rdy=1", out_valid, par_err, in_ready);
        else passes++;
        in_par = 1'b1;
        cycle();
        checks++; if (out_y !== 8'h80 || out_valid !== 1'b1 || par_err !== 1'b1)
            $display("FAIL par_good got y=%h v=%b err=%b exp y=80 v=1 err=1", out_y, out_valid, par_err);
        else passes++;
        in_par    = 1'b0;
        out_ready = 1'b1;
        cycle();
        checks++; if (dec_cnt !== 4'd1 || out_valid !== 1'b0 || par_err !== 1'b1)
            $display("FAIL par_pop got cnt=%0d v=%b err=%b exp cnt=1 v=0 err=1", dec_cnt, out_valid, par_err);
        else passes++;
        drive(1'b0, 3'd0);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0);
        test_reset();
        test_walking();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_counter_wrap();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decoder_link_rx.md
Name: decoder_link_rx

Overview:
- Receiving end of the reduced-line encoded link: accepts a binary line index (a2..a0) per transfer and regenerates the one-hot line set y7..y0.
- Code words are buffered in a 2-entry queue with valid/ready handshakes on both sides.
- Outputs are registered; the block also counts delivered words.
- Sits between the link pins/retiming stage and the consumer of the one-hot lines.

Parameters:
- CODE_W, 3, width of the encoded index. The one-hot width is a derived constant OUT_W = 2**CODE_W, not a parameter.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code (and in_par) valid.
- in_ready  output  1  block can accept a word this cycle.
- in_code  input  CODE_W  encoded index {a2,a1,a0}; a0 = LSB.
- in_par  input  1  parity bit. Present only with PARITY_CHECK_EN.
- out_valid  output  1  out_y/out_code hold a decoded word.
- out_ready  input  1  consumer accepts the word.
- out_y  output  OUT_W  one-hot line set; bit k = y_k.
- out_code  output  CODE_W  index of the word currently at the output.
- dec_cnt  output  CNT_W  number of words delivered.
- par_err  output  1  sticky parity error. Present only with PARITY_CHECK_EN.

Behaviour:
- Reset (rst_n=0, async assert; deassert takes effect on the next clk edge):
  - Queue empty.
  - out_valid=0, out_y=0, out_code=0, dec_cnt=0, par_err=0.
  - in_ready=1, but no transfer is taken while rst_n=0.
- Queue occupancy FSM:
  - States: EMPTY, ONE, FULL.
  - push = in_valid && in_ready (and parity ok when the feature is on); pop = out_valid && out_ready.
  - EMPTY: push -> ONE.
  - ONE: push&&!pop -> FULL; pop&&!push -> EMPTY; push&&pop -> ONE, with the new word becoming the head.
  - FULL: pop -> ONE. No push is possible.
- in_ready = (state != FULL). It comes from registered state only and never combinationally depends on out_ready.
- out_valid = (state != EMPTY).
- Latency: a word pushed at edge N is visible on out_* after edge N, i.e. in the cycle following acceptance. There is no combinational path from in_* to out_*.
- Decode: out_y = 1 << head_code, exactly one bit set; out_code = head_code. When EMPTY, out_y = 0 and out_code = 0.
- Stability: while out_valid && !out_ready, out_y and out_code hold constant.
- Order: words are delivered strictly FIFO; no reordering or duplication.
- dec_cnt: +1 on every pop; wraps modulo 2**CNT_W (all-ones -> 0).
- Reset mid-operation: queued words are discarded and the block returns to the reset values above.

Optional Feature:
- PARITY_CHECK_EN defined:
  - in_par and par_err ports exist. Even parity: a word is good when in_par == ^in_code.
  - A bad word still completes the input handshake (in_ready is unaffected) but is dropped, not enqueued.
  - par_err sets on the edge after a bad word and stays set until reset.
  - A bad word arriving together with a pop does not block the pop.
- PARITY_CHECK_EN undefined:
  - in_par and par_err ports are absent.
  - Every accepted word is enqueued.

Decomposition:
- Package enc_link_pkg holds:
  - CODE_W default and OUT_W.
  - typedef q_state_t {EMPTY, ONE, FULL}.
  - Function onehot_of(code) returning the OUT_W one-hot vector.
- One sub-module: link_fifo2, a 2-entry CODE_W-wide queue with push/pop/state.
- decoder_link_rx instantiates link_fifo2 and adds the registered decode, counter and parity logic.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> out_valid=0, out_y=0x00, dec_cnt=0, in_ready=1.
- Walking indices: in_code 0..7 with out_ready=1 -> out_y = 0x01, 0x02, 0x04 ... 0x80, each one cycle after acceptance; dec_cnt=8.
- Backpressure: out_ready=0, push codes 5 then 2 -> in_ready=0 after the second push and out_y holds 0x20. Then out_ready=1 -> 0x20 then 0x04 are delivered and in_ready returns to 1.
- Simultaneous push/pop in ONE: head=3, push 6 while popping -> next cycle out_y=0x40, state ONE, dec_cnt +1.
- Counter wrap with CNT_W=4: 17 pops -> dec_cnt=1.
- PARITY_CHECK_EN on: code 7 with in_par=0 -> word dropped, out_valid stays 0, par_err=1. Then code 7 with in_par=1 -> out_y=0x80 is delivered and par_err remains 1.
